// File: rtl/addsub_pkg.sv
// +--------------------------------------------------------------------------+
// | addsub_pkg: shared types and sizing helpers for the sliced add/sub block  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package addsub_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int SLICE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice index counter needs at least one bit even for a single-slice build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// +--------------------------------------------------------------------------+
// | addsub_slice: combinational SLICE-bit add/sub with carry into the MSB     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [SLICE-1:0] w_bx;
  logic [SLICE:0]   w_full;

  assign w_bx   = b_i ^ {SLICE{sub_i}};
  assign w_full = {1'b0, a_i} + {1'b0, w_bx} + {{SLICE{1'b0}}, cin_i};
  assign sum_o  = w_full[SLICE-1:0];
  assign cout_o = w_full[SLICE];

  // Carry into the MSB comes from adding the lower SLICE-1 bits on their own.
  generate
    if (SLICE > 1) begin : g_wide
      logic [SLICE-1:0] w_low;
      assign w_low      = {1'b0, a_i[SLICE-2:0]} + {1'b0, w_bx[SLICE-2:0]}
                        + {{(SLICE-1){1'b0}}, cin_i};
      assign c_msb_in_o = w_low[SLICE-1];
    end else begin : g_single
      assign c_msb_in_o = cin_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | addsub_seq_ctrl: WIDTH-bit add/sub sequenced over one SLICE-bit datapath  |
// | Optional signed-overflow output enabled by ADDSUB_OVF_EN. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             carry_out
);

  localparam int NSL = nslice(WIDTH, SLICE);
  localparam int IW  = idx_width(NSL);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  addsub_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SLICE-1:0] w_sum;
  logic             w_cout, w_c_msb;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a_i        (a_q[int'(idx_q)*SLICE +: SLICE]),
    .b_i        (b_q[int'(idx_q)*SLICE +: SLICE]),
    .sub_i      (sub_q),
    .cin_i      (carry_q),
    .sum_o      (w_sum),
    .cout_o     (w_cout),
    .c_msb_in_o (w_c_msb)
  );

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = w_c_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          carry_d = op_sub;   // +1 of the two's-complement negate
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*SLICE +: SLICE] = w_sum;
        carry_d = w_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = w_cout;
`ifdef ADDSUB_OVF_EN
          ovf_d   = w_c_msb ^ w_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_addsub_seq_ctrl: directed and randomized bench for addsub_seq_ctrl     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_addsub_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        carry_out;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  addsub_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the whole operands.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                output logic [15:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r = 16'(ua - ub);
      c = (ua >= ub);
      s = sa - sb;
    end else begin
      r = 16'(ua + ub);
      c = (ua + ub) > 65535;
      s = sa + sb;
    end
    v = (s > 32767) || (s < -32768);
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output int lat);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++;
    if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result got=%h exp=0000", result); end
    n_vec++;
    if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
`ifdef ADDSUB_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_directed();
    logic [15:0] ta[7] = '{16'h1234, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h0003, 16'hFFFF};
    logic [15:0] tb[7] = '{16'h0FF1, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0004, 16'hFFFF};
    logic        ts[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] er;
    logic        ec, ev;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      model(ta[i], tb[i], ts[i], er, ec, ev);
      issue(ta[i], tb[i], ts[i], lat);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
      n_vec++;
      if (result !== er) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, er); end
      n_vec++;
      if (carry_out !== ec) begin n_err++; $display("FAIL dir%0d_carry got=%b exp=%b", i, carry_out, ec); end
`ifdef ADDSUB_OVF_EN
      n_vec++;
      if (ovf !== ev) begin n_err++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, ev); end
`endif
      release_out();
    end
  endtask

  task automatic test_hold_done();
    logic [15:0] er;
    logic        ec, ev;
    int          lat, bad;
    model(16'hA5A5, 16'h1111, 1'b1, er, ec, ev);
    issue(16'hA5A5, 16'h1111, 1'b1, lat);
    bad = 0;
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h3333; op_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== er || in_ready !== 1'b0 || out_valid !== 1'b1 || carry_out !== ec) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_stable got=%0d bad cycles (result=%h in_ready=%b) exp=0", bad, result, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL hold_no_capture got=%0d busy cycles exp=0", bad); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, er;
    logic        s, ec, ev;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      model(a, b, s, er, ec, ev);
      issue(a, b, s, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      n_vec++;
      if (lat !== 4 || result !== er || carry_out !== ec) begin
        n_err++;
        $display("FAIL rand%0d %h%s%h got=%h/c%b/lat%0d exp=%h/c%b/lat4",
                 i, a, s ? "-" : "+", b, result, carry_out, lat, er, ec);
      end
`ifdef ADDSUB_OVF_EN
      n_vec++;
      if (ovf !== ev) begin n_err++; $display("FAIL rand%0d_ovf got=%b exp=%b", i, ovf, ev); end
`endif
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qr[$];
    logic        qc[$];
    logic [15:0] a, b, er;
    logic        s, ec, ev;
    int          cyc, last, accepts, checked;
    cyc = 0; last = -1; accepts = 0; checked = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (checked < 4 && cyc < 100) begin
      if (out_valid) begin
        n_vec++;
        if (qr.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected got=%h exp=none", result);
        end else begin
          er = qr.pop_front();
          ec = qc.pop_front();
          if (result !== er || carry_out !== ec) begin
            n_err++; $display("FAIL b2b_result got=%h/c%b exp=%h/c%b", result, carry_out, er, ec);
          end
        end
        checked++;
      end
      if (in_ready && accepts < 4) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != 6) begin n_err++; $display("FAIL b2b_interval got=%0d exp=6", cyc - last); end
        end
        last = cyc;
        a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
        model(a, b, s, er, ec, ev);
        qr.push_back(er);
        qc.push_back(ec);
        op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
        accepts++;
      end else if (accepts >= 4) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (checked != 4) begin n_err++; $display("FAIL b2b_timeout got=%0d results exp=4", checked); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, bad;
    @(negedge clk);
    op_a = 16'h1357; op_b = 16'h2468; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state got=ov%b/ir%b exp=ov0/ir1", out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL midrst_no_valid got=%0d cycles exp=0", bad); end
    issue(16'hFFFF, 16'h0001, 1'b0, lat);
    n_vec++;
    if (lat !== 4 || result !== 16'h0000 || carry_out !== 1'b1) begin
      n_err++; $display("FAIL midrst_next got=%h/c%b/lat%0d exp=0000/c1/lat4", result, carry_out, lat);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_done();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
